context_scheduler: RTL and testbench

Parametrised round-robin process scheduler that replaces the single saved-line, two-process context switch in the processor top. It holds up to NPROC user processes, each with a saved resume address. It time-slices between them with a programmable instruction quantum and redirects the PC on every switch. When the last process ends, control returns to the OS entry address. It sits between the control unit and the PC's next-address mux.

---
 rtl/context_pkg.sv | 8 +
 rtl/rr_pick.sv | 29 ++
 rtl/context_scheduler.sv | 122 ++++++++++++
 tb/tb_context_scheduler.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/context_pkg.sv
// context_pkg: shared types and default parameters for the context scheduler
package context_pkg;
  localparam int NPROC_DEF = 4;
  localparam int AW_DEF = 32;
  localparam int QW_DEF = 16;
  typedef enum logic [1:0] {FREE, READY, RUNNING, DONE} slot_state_t;
  typedef enum logic [1:0] {IDLE, SELECT, RUN} sched_state_t;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: rotating-priority picker, first set bit of i_ready at or after i_start (wrapping)
//   i_ready  per-slot ready mask
//   i_start  slot examined first
//   o_found  at least one slot ready
//   o_sel    chosen slot
module rr_pick #(
  parameter int N = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  i_ready,
  input  logic [PW-1:0] i_start,
  output logic          o_found,
  output logic [PW-1:0] o_sel
);
  logic [PW-1:0] w_idx;
  // scan from farthest to nearest so the nearest ready slot is written last
  always_comb begin
    o_found = 1'b0;
    o_sel = '0;
    w_idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_idx = PW'((int'(i_start) + k) % N);
      if (i_ready[w_idx]) begin
        o_found = 1'b1;
        o_sel = w_idx;
      end
    end
  end
endmodule

// File: rtl/context_scheduler.sv
// context_scheduler: round-robin time-sliced process scheduler driving PC redirects
//   i_clk/i_reset      clock, synchronous active-high reset
//   i_retire           one instruction retired this cycle
//   i_quantum          slice length in retires, 0 disables preemption
//   i_load_*           register a process entry address into a slot
//   i_cur_pc           next-PC mux output, saved on preemption
//   i_end_of_process   running process finished
//   o_pc_override      PC must load o_new_pc this cycle
//   o_new_pc           redirect address, held between redirects
//   o_cur_pid          slot currently running
//   o_in_program       a user process is running
//   o_all_done         every loaded process finished, cleared by the next load
module context_scheduler
  import context_pkg::*;
#(
  parameter int NPROC = NPROC_DEF,
  parameter int AW = AW_DEF,
  parameter int QW = QW_DEF,
  parameter logic [AW-1:0] OS_ENTRY = '0,
  localparam int PW = $clog2(NPROC)
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_retire,
  input  logic [QW-1:0] i_quantum,
  input  logic          i_load_valid,
  input  logic [PW-1:0] i_load_pid,
  input  logic [AW-1:0] i_load_addr,
  input  logic [AW-1:0] i_cur_pc,
  input  logic          i_end_of_process,
  output logic          o_pc_override,
  output logic [AW-1:0] o_new_pc,
  output logic [PW-1:0] o_cur_pid,
  output logic          o_in_program,
  output logic          o_all_done
);
  sched_state_t  r_state;
  slot_state_t   r_slot [NPROC];
  logic [AW-1:0] r_saved_pc [NPROC];
  logic [PW-1:0] r_cur_pid;
  logic [QW-1:0] r_cnt;
  logic [AW-1:0] r_new_pc;
  logic          r_all_done;
  logic [NPROC-1:0] w_ready;
  logic [NPROC-1:0] w_done;
  logic [PW-1:0] w_start;
  logic [PW-1:0] w_sel;
  logic          w_found;
  logic          w_load_ok;
  logic          w_expire;
  logic [AW-1:0] w_pick_pc;
  for (genvar s = 0; s < NPROC; s++) begin : g_mask
    assign w_ready[s] = r_slot[s] == READY;
    assign w_done[s] = r_slot[s] == DONE;
  end
  // the running slot is offered last by starting the scan just after it
  assign w_start = (r_cur_pid == PW'(NPROC - 1)) ? '0 : r_cur_pid + PW'(1);
  rr_pick #(.N(NPROC), .PW(PW)) u_pick (
    .i_ready(w_ready),
    .i_start(w_start),
    .o_found(w_found),
    .o_sel(w_sel)
  );
  // a load may not disturb the running slot nor the slot being dispatched right now
  assign w_load_ok = i_load_valid && r_slot[i_load_pid] != RUNNING &&
                     !(r_state == SELECT && w_found && i_load_pid == w_sel);
  // the counter holds the quantum sampled at dispatch, so 0 never expires
  assign w_expire = i_retire && r_cnt == QW'(1);
  assign w_pick_pc = w_found ? r_saved_pc[w_sel] : OS_ENTRY;
  assign o_pc_override = r_state == SELECT;
  assign o_new_pc = o_pc_override ? w_pick_pc : r_new_pc;
  assign o_cur_pid = r_cur_pid;
  assign o_in_program = r_state == RUN;
  assign o_all_done = r_all_done;
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= IDLE;
      r_cur_pid <= '0;
      r_cnt <= '0;
      r_new_pc <= '0;
      r_all_done <= 1'b0;
      for (int k = 0; k < NPROC; k++) begin
        r_slot[k] <= FREE;
        r_saved_pc[k] <= '0;
      end
    end else begin
      case (r_state)
        IDLE: if (|w_ready || w_load_ok) r_state <= SELECT;
        SELECT: begin
          r_new_pc <= w_pick_pc;
          if (w_found) begin
            r_cur_pid <= w_sel;
            r_slot[w_sel] <= RUNNING;
            r_cnt <= i_quantum;
            r_state <= RUN;
          end else begin
            r_state <= IDLE;
            if (|w_done) r_all_done <= 1'b1;
          end
        end
        RUN: begin
          if (i_end_of_process) begin
            r_slot[r_cur_pid] <= DONE;
            r_state <= SELECT;
          end else if (w_expire) begin
            r_saved_pc[r_cur_pid] <= i_cur_pc;
            r_slot[r_cur_pid] <= READY;
            r_state <= SELECT;
          end else if (i_retire && r_cnt != '0) begin
            r_cnt <= r_cnt - QW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
      if (w_load_ok) begin
        r_saved_pc[i_load_pid] <= i_load_addr;
        r_slot[i_load_pid] <= READY;
        r_all_done <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_context_scheduler.sv
// tb_context_scheduler: scoreboard bench for context_scheduler redirects and slot bookkeeping
module tb_context_scheduler;
  import context_pkg::*;
  localparam logic [31:0] OS = 32'h0;
  typedef struct {
    logic [31:0] pc;
    logic [1:0]  pid;
  } exp_t;
  logic        clk = 1'b0;
  logic        rst;
  logic        i_retire;
  logic [15:0] i_quantum;
  logic        i_load_valid;
  logic [1:0]  i_load_pid;
  logic [31:0] i_load_addr;
  logic [31:0] i_cur_pc;
  logic        i_eop;
  logic        o_pc_override;
  logic [31:0] o_new_pc;
  logic [1:0]  o_cur_pid;
  logic        o_in_program;
  logic        o_all_done;
  int tests = 0;
  int fails = 0;
  exp_t q[$];
  exp_t mon_e;
  logic chk_pid = 1'b0;
  logic [1:0] exp_pid;
  always #5 clk = ~clk;
  context_scheduler #(.NPROC(4), .AW(32), .QW(16), .OS_ENTRY(OS)) dut (
    .i_clk(clk),
    .i_reset(rst),
    .i_retire(i_retire),
    .i_quantum(i_quantum),
    .i_load_valid(i_load_valid),
    .i_load_pid(i_load_pid),
    .i_load_addr(i_load_addr),
    .i_cur_pc(i_cur_pc),
    .i_end_of_process(i_eop),
    .o_pc_override(o_pc_override),
    .o_new_pc(o_new_pc),
    .o_cur_pid(o_cur_pid),
    .o_in_program(o_in_program),
    .o_all_done(o_all_done)
  );
  always @(negedge clk) begin
    if (chk_pid) begin
      tests++;
      if (o_cur_pid !== exp_pid) begin
        fails++;
        $display("FAIL redirect_pid: cur_pid %0d, want %0d", o_cur_pid, exp_pid);
      end
      chk_pid = 1'b0;
    end
    if (o_pc_override === 1'b1) begin
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_redirect: new_pc %h, none expected", o_new_pc);
      end else begin
        mon_e = q.pop_front();
        if (o_new_pc !== mon_e.pc) begin
          fails++;
          $display("FAIL redirect_pc: new_pc %h, want %h", o_new_pc, mon_e.pc);
        end
        chk_pid = 1'b1;
        exp_pid = mon_e.pid;
      end
    end
  end
  task automatic cyc(input logic ret, input logic eop, input logic [31:0] pc);
    i_retire = ret;
    i_eop = eop;
    i_cur_pc = pc;
    @(posedge clk);
    #1;
    i_retire = 1'b0;
    i_eop = 1'b0;
  endtask
  task automatic ld(input logic [1:0] pid, input logic [31:0] addr);
    i_load_valid = 1'b1;
    i_load_pid = pid;
    i_load_addr = addr;
    @(posedge clk);
    #1;
    i_load_valid = 1'b0;
  endtask
  task automatic expect_redirect(input logic [31:0] pc, input logic [1:0] pid);
    exp_t e;
    e.pc = pc;
    e.pid = pid;
    q.push_back(e);
  endtask
  task automatic wait_run(input string name);
    int k;
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      if (o_in_program === 1'b1) break;
    end
    tests++;
    if (k == 20) begin
      fails++;
      $display("FAIL %s_run_timeout: in_program %b, want 1", name, o_in_program);
    end
  endtask
  task automatic drain(input string name);
    for (int k = 0; k < 20 && q.size() != 0; k++) begin
      @(negedge clk);
      #1;
    end
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL %s_drain: %0d redirects outstanding, want 0", name, q.size());
      q.delete();
    end
  endtask
  task automatic test_reset();
    tests++;
    if ({o_pc_override, o_new_pc, o_cur_pid, o_in_program, o_all_done} !== 36'h0) begin
      fails++;
      $display("FAIL reset_outputs: ovr %b pc %h pid %0d run %b done %b, want all 0",
               o_pc_override, o_new_pc, o_cur_pid, o_in_program, o_all_done);
    end
  endtask
  task automatic test_quantum_switch();
    i_quantum = 16'd3;
    expect_redirect(32'h100, 2'd0);
    ld(2'd0, 32'h100);
    ld(2'd1, 32'h200);
    wait_run("q3_first");
    cyc(1'b1, 1'b0, 32'h104);
    cyc(1'b1, 1'b0, 32'h108);
    expect_redirect(32'h200, 2'd1);
    cyc(1'b1, 1'b0, 32'h10C);
    wait_run("q3_pid1");
    cyc(1'b1, 1'b0, 32'h204);
    cyc(1'b1, 1'b0, 32'h208);
    expect_redirect(32'h10C, 2'd0);
    cyc(1'b1, 1'b0, 32'h20C);
    wait_run("q3_resume0");
    drain("quantum_switch");
  endtask
  task automatic test_end_of_process();
    cyc(1'b1, 1'b0, 32'h110);
    cyc(1'b1, 1'b0, 32'h114);
    expect_redirect(32'h20C, 2'd1);
    cyc(1'b1, 1'b0, 32'h118);
    wait_run("eop_pid1");
    expect_redirect(32'h118, 2'd0);
    cyc(1'b0, 1'b1, 32'h0);
    wait_run("eop_pid0");
    expect_redirect(OS, 2'd0);
    cyc(1'b0, 1'b1, 32'h0);
    cyc(1'b0, 1'b0, 32'h0);
    tests++;
    if (o_in_program !== 1'b0 || o_all_done !== 1'b1) begin
      fails++;
      $display("FAIL eop_all_done: run %b done %b, want run 0 done 1", o_in_program, o_all_done);
    end
    drain("end_of_process");
  endtask
  task automatic test_eop_with_expiry();
    i_quantum = 16'd1;
    expect_redirect(32'h300, 2'd2);
    ld(2'd2, 32'h300);
    wait_run("eopx");
    expect_redirect(OS, 2'd2);
    cyc(1'b1, 1'b1, 32'h304);
    cyc(1'b0, 1'b0, 32'h0);
    tests++;
    if (dut.r_slot[2] !== DONE || dut.r_saved_pc[2] !== 32'h300) begin
      fails++;
      $display("FAIL eopx_slot: state %0d saved %h, want DONE(3) 00000300",
               dut.r_slot[2], dut.r_saved_pc[2]);
    end
    tests++;
    if (o_all_done !== 1'b1) begin
      fails++;
      $display("FAIL eopx_all_done: %b, want 1", o_all_done);
    end
    drain("eop_with_expiry");
  endtask
  task automatic test_wrap();
    expect_redirect(32'h400, 2'd3);
    ld(2'd3, 32'h400);
    tests++;
    if (o_all_done !== 1'b0) begin
      fails++;
      $display("FAIL load_clears_done: %b, want 0", o_all_done);
    end
    ld(2'd1, 32'h500);
    wait_run("wrap_pid3");
    expect_redirect(32'h500, 2'd1);
    cyc(1'b1, 1'b0, 32'h404);
    wait_run("wrap_pid1");
    expect_redirect(32'h404, 2'd3);
    cyc(1'b1, 1'b0, 32'h504);
    wait_run("wrap_back3");
    expect_redirect(32'h504, 2'd1);
    cyc(1'b1, 1'b0, 32'h408);
    wait_run("wrap_again1");
    expect_redirect(32'h408, 2'd3);
    cyc(1'b0, 1'b1, 32'h0);
    wait_run("wrap_only3");
    expect_redirect(32'h40C, 2'd3);
    cyc(1'b1, 1'b0, 32'h40C);
    wait_run("wrap_reselect3");
    expect_redirect(OS, 2'd3);
    cyc(1'b0, 1'b1, 32'h0);
    cyc(1'b0, 1'b0, 32'h0);
    drain("wrap");
  endtask
  task automatic test_quantum_zero();
    logic dropped = 1'b0;
    i_quantum = 16'd0;
    expect_redirect(32'h600, 2'd3);
    ld(2'd3, 32'h600);
    wait_run("q0");
    for (int k = 0; k < 1000; k++) begin
      cyc(1'b1, 1'b0, 32'h600 + 32'(4 * k));
      if (o_in_program !== 1'b1) dropped = 1'b1;
    end
    tests++;
    if (dropped !== 1'b0) begin
      fails++;
      $display("FAIL q0_in_program: dropped %b, want 0", dropped);
    end
    drain("quantum_zero");
  endtask
  task automatic test_load_running();
    ld(2'd3, 32'h999);
    cyc(1'b0, 1'b0, 32'h0);
    tests++;
    if (dut.r_saved_pc[3] !== 32'h600 || dut.r_slot[3] !== RUNNING) begin
      fails++;
      $display("FAIL load_running_slot: saved %h state %0d, want 00000600 RUNNING(2)",
               dut.r_saved_pc[3], dut.r_slot[3]);
    end
    tests++;
    if (o_in_program !== 1'b1 || o_cur_pid !== 2'd3) begin
      fails++;
      $display("FAIL load_running_out: run %b pid %0d, want 1 3", o_in_program, o_cur_pid);
    end
  endtask
  task automatic test_reset_mid_run();
    rst = 1'b1;
    cyc(1'b1, 1'b0, 32'h700);
    rst = 1'b0;
    test_reset();
    repeat (5) cyc(1'b0, 1'b0, 32'h0);
    tests++;
    if (o_in_program !== 1'b0 || dut.r_slot[3] !== FREE || dut.r_saved_pc[3] !== 32'h0) begin
      fails++;
      $display("FAIL reset_discard: run %b state %0d saved %h, want 0 FREE(0) 0",
               o_in_program, dut.r_slot[3], dut.r_saved_pc[3]);
    end
    drain("reset_mid_run");
  endtask
  initial begin
    rst = 1'b1;
    i_retire = 1'b0;
    i_quantum = 16'd0;
    i_load_valid = 1'b0;
    i_load_pid = 2'd0;
    i_load_addr = 32'h0;
    i_cur_pc = 32'h0;
    i_eop = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    test_reset();
    test_quantum_switch();
    test_end_of_process();
    test_eop_with_expiry();
    test_wrap();
    test_quantum_zero();
    test_load_running();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
